// File: rtl/data_bus_arbiter.sv
// Data-memory port arbiter: m0 fixed priority, m1/m2 round-robin.
// Latches one transfer, holds it until completion or watchdog abort.
module data_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m0_rw,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_cplt,
  output logic        m0_err,
  input  logic [1:0]  m1_rw,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_cplt,
  output logic        m1_err,
  input  logic [1:0]  m2_rw,
  input  logic [1:0]  m2_size,
  input  logic [31:0] m2_addr,
  input  logic [31:0] m2_wdata,
  output logic [31:0] m2_rdata,
  output logic        m2_cplt,
  output logic        m2_err,
  output logic [1:0]  data_rw,
  output logic [1:0]  data_size,
  output logic [31:0] data_address,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_rw_cplt,
  output logic [1:0]  grant_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_REL
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  own_q;
  logic        rr_q;
  logic [1:0]  rw_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] cnt_q;

  logic        req0;
  logic        req1;
  logic        req2;
  logic        any_req;
  logic [1:0]  win;
  logic [1:0]  sel_rw;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        done;
  logic        tmo;
  logic        rel;

  assign req0    = m0_rw[1];
  assign req1    = m1_rw[1];
  assign req2    = m2_rw[1];
  assign any_req = req0 | req1 | req2;

  // rr_q = 0 favours m1, 1 favours m2; a lone m1/m2 requester always wins
  always_comb begin
    win = 2'd2;
    if (req0)
      win = 2'd0;
    else if (req1 && req2)
      win = rr_q ? 2'd2 : 2'd1;
    else if (req1)
      win = 2'd1;
  end

  always_comb begin
    sel_rw    = m2_rw;
    sel_size  = m2_size;
    sel_addr  = m2_addr;
    sel_wdata = m2_wdata;
    unique case (win)
      2'd0: begin
        sel_rw    = m0_rw;
        sel_size  = m0_size;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
      end
      2'd1: begin
        sel_rw    = m1_rw;
        sel_size  = m1_size;
        sel_addr  = m1_addr;
        sel_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  // completion beats a same-cycle timeout
  assign done = (state_q == S_BUSY) && data_rw_cplt;
  assign tmo  = (state_q == S_BUSY) && !data_rw_cplt
             && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_BUSY;
      S_BUSY:  if (done || tmo) state_d = S_REL;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q   <= 2'd0;
      rr_q    <= 1'b0;
      rw_q    <= 2'd0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      if (state_q == S_IDLE && any_req) begin
        own_q   <= win;
        rw_q    <= sel_rw;
        size_q  <= sel_size;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        cnt_q   <= 16'd0;
        if (win == 2'd1)
          rr_q <= 1'b1;
        else if (win == 2'd2)
          rr_q <= 1'b0;
      end
      if (done) begin
        rdata_q <= rw_q[0] ? 32'd0 : data_rdata;
        err_q   <= 1'b0;
      end else if (tmo) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b1;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign rel = (state_q == S_REL);

  always_comb begin
    busy         = (state_q != S_IDLE);
    grant_id     = busy ? own_q : 2'd3;
    data_rw      = (state_q == S_BUSY) ? rw_q : 2'd0;
    data_size    = size_q;
    data_address = addr_q;
    data_wdata   = wdata_q;
    m0_cplt      = rel && (own_q == 2'd0);
    m1_cplt      = rel && (own_q == 2'd1);
    m2_cplt      = rel && (own_q == 2'd2);
    m0_err       = m0_cplt && err_q;
    m1_err       = m1_cplt && err_q;
    m2_err       = m2_cplt && err_q;
    m0_rdata     = m0_cplt ? rdata_q : 32'd0;
    m1_rdata     = m1_cplt ? rdata_q : 32'd0;
    m2_rdata     = m2_cplt ? rdata_q : 32'd0;
  end

endmodule
